// File: rtl/writeback_regfile.sv
// Y86 writeback stage: owns the 15-entry register file and commits valE/valM through one write port.
// Optional macro WB_BYPASS_EN forwards the in-flight write data to the decode read ports.
module writeback_regfile #(
    parameter int DATA_W  = 64,
    parameter int NREG    = 15,
    parameter int RSP_IDX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        rA_i,
    input  logic [3:0]        rB_i,
    input  logic              cnd_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic [3:0]        srcA_i,
    input  logic [3:0]        srcB_i,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    output logic              busy_o,
    output logic              halt_o
);

    localparam logic [3:0] IDX_NONE  = 4'hF;
    localparam logic [3:0] IDX_RSP   = 4'(RSP_IDX);
    localparam logic [3:0] IC_HALT   = 4'h1;
    localparam logic [3:0] IC_RRMOVL = 4'h2;
    localparam logic [3:0] IC_IRMOVL = 4'h3;
    localparam logic [3:0] IC_MRMOVL = 4'h5;
    localparam logic [3:0] IC_ALU    = 4'h6;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHL  = 4'hA;
    localparam logic [3:0] IC_POPL   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WR_E   = 2'd1,
        S_WR_M   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ready;
    logic              r_busy;
    logic              r_halt;
    logic [3:0]        r_dste;
    logic [3:0]        r_dstm;
    logic [DATA_W-1:0] r_vale;
    logic [DATA_W-1:0] r_valm;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [3:0]        w_dste;
    logic [3:0]        w_dstm;
    logic              w_accept;
    logic              w_we;
    logic [3:0]        w_widx;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_vala_arr;
    logic [DATA_W-1:0] w_valb_arr;

    assign w_accept = valid_i && r_ready;

    // Destination decode; unknown icodes fall into the no-write default like NOP.
    always_comb begin
        w_dste = IDX_NONE;
        w_dstm = IDX_NONE;
        case (icode_i)
            IC_RRMOVL: begin
                if (cnd_i) w_dste = rB_i;
                else       w_dste = IDX_NONE;
            end
            IC_IRMOVL, IC_ALU:           w_dste = rB_i;
            IC_CALL, IC_RET, IC_PUSHL:   w_dste = IDX_RSP;
            IC_MRMOVL:                   w_dstm = rA_i;
            IC_POPL: begin
                w_dste = IDX_RSP;
                w_dstm = rA_i;
            end
            default: begin
                w_dste = IDX_NONE;
                w_dstm = IDX_NONE;
            end
        endcase
    end

    // Next-state and write-port selection; E is always committed before M.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_widx      = r_dste;
        w_wdata     = r_vale;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (icode_i == IC_HALT)      w_state_nxt = S_HALTED;
                    else if (w_dste != IDX_NONE) w_state_nxt = S_WR_E;
                    else if (w_dstm != IDX_NONE) w_state_nxt = S_WR_M;
                    else                         w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR_E: begin
                w_we    = 1'b1;
                w_widx  = r_dste;
                w_wdata = r_vale;
                if (r_dstm != IDX_NONE) w_state_nxt = S_WR_M;
                else                    w_state_nxt = S_IDLE;
            end
            S_WR_M: begin
                w_we        = 1'b1;
                w_widx      = r_dstm;
                w_wdata     = r_valm;
                w_state_nxt = S_IDLE;
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register, request latch and status flags decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_halt  <= 1'b0;
            r_dste  <= IDX_NONE;
            r_dstm  <= IDX_NONE;
            r_vale  <= {DATA_W{1'b0}};
            r_valm  <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt == S_WR_E) || (w_state_nxt == S_WR_M);
            r_halt  <= (w_state_nxt == S_HALTED);
            if (w_accept) begin
                r_dste <= w_dste;
                r_dstm <= w_dstm;
                r_vale <= valE_i;
                r_valm <= valM_i;
            end else begin
                r_dste <= r_dste;
                r_dstm <= r_dstm;
                r_vale <= r_vale;
                r_valm <= r_valm;
            end
        end
    end

    // Register array; reset loads each entry with its own index.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
        end else if (w_we && (w_widx != IDX_NONE)) begin
            r_regs[w_widx] <= w_wdata;
        end
    end

    assign w_vala_arr = (srcA_i == IDX_NONE) ? {DATA_W{1'b0}} : r_regs[srcA_i];
    assign w_valb_arr = (srcB_i == IDX_NONE) ? {DATA_W{1'b0}} : r_regs[srcB_i];

`ifdef WB_BYPASS_EN
    assign valA_o = (w_we && (srcA_i == w_widx) && (srcA_i != IDX_NONE)) ? w_wdata : w_vala_arr;
    assign valB_o = (w_we && (srcB_i == w_widx) && (srcB_i != IDX_NONE)) ? w_wdata : w_valb_arr;
`else
    assign valA_o = w_vala_arr;
    assign valB_o = w_valb_arr;
`endif

    assign ready_o = r_ready;
    assign busy_o  = r_busy;
    assign halt_o  = r_halt;

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against a queue-based model of pending register writes.
module tb_writeback_regfile;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  icode_i = 4'h0;
    logic [3:0]  rA_i = 4'h0;
    logic [3:0]  rB_i = 4'h0;
    logic        cnd_i = 1'b0;
    logic [63:0] valE_i = 64'h0;
    logic [63:0] valM_i = 64'h0;
    logic [3:0]  srcA_i = 4'h0;
    logic [3:0]  srcB_i = 4'h0;
    logic [63:0] valA_o;
    logic [63:0] valB_o;
    logic        busy_o;
    logic        halt_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_regs [15];
    logic [3:0]  q_idx [$];
    logic [63:0] q_dat [$];
    logic        m_halted;

    writeback_regfile #(.DATA_W(64), .NREG(15), .RSP_IDX(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i), .cnd_i(cnd_i),
        .valE_i(valE_i), .valM_i(valM_i), .srcA_i(srcA_i), .srcB_i(srcB_i),
        .valA_o(valA_o), .valB_o(valB_o), .busy_o(busy_o), .halt_o(halt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [3:0] s);
        if (s == 4'hF) return 64'h0;
`ifdef WB_BYPASS_EN
        if (q_idx.size() > 0 && q_idx[0] == s) return q_dat[0];
`endif
        return m_regs[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = 64'(i);
        q_idx.delete();
        q_dat.delete();
        m_halted = 1'b0;
    endtask

    task automatic check_outputs();
        chk("ready", {63'h0, ready_o}, {63'h0, (q_idx.size() == 0) && !m_halted});
        chk("busy",  {63'h0, busy_o},  {63'h0, q_idx.size() != 0});
        chk("halt",  {63'h0, halt_o},  {63'h0, m_halted});
        chk("valA",  valA_o, exp_rd(srcA_i));
        chk("valB",  valB_o, exp_rd(srcB_i));
    endtask

    // One clock: drive at negedge, check, then advance the model at posedge.
    task automatic cycle(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
        logic [3:0] de;
        logic [3:0] dm;
        @(negedge clk_i);
        valid_i = v; icode_i = ic; rA_i = ra; rB_i = rb; cnd_i = c;
        valE_i = ve; valM_i = vm; srcA_i = sa; srcB_i = sb;
        #1;
        check_outputs();
        @(posedge clk_i);
        if (q_idx.size() > 0) begin
            m_regs[q_idx[0]] = q_dat[0];
            void'(q_idx.pop_front());
            void'(q_dat.pop_front());
        end else if (!m_halted && v) begin
            de = 4'hF;
            dm = 4'hF;
            case (ic)
                4'h2:             de = c ? rb : 4'hF;
                4'h3, 4'h6:       de = rb;
                4'h8, 4'h9, 4'hA: de = 4'h4;
                4'hB: begin de = 4'h4; dm = ra; end
                4'h5:             dm = ra;
                default: ;
            endcase
            if (ic == 4'h1) begin
                m_halted = 1'b1;
            end else begin
                if (de != 4'hF) begin q_idx.push_back(de); q_dat.push_back(ve); end
                if (dm != 4'hF) begin q_idx.push_back(dm); q_dat.push_back(vm); end
            end
        end
    endtask

    task automatic idle(input int n, input logic [3:0] sa, input logic [3:0] sb);
        for (int k = 0; k < n; k++) cycle(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, sa, sb);
    endtask

    // Assert reset mid-cycle and verify the whole array reads back its indices.
    task automatic do_reset();
        @(negedge clk_i);
        #2;
        valid_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        chk("rst_halt",  {63'h0, halt_o},  64'h0);
        chk("rst_ready", {63'h0, ready_o}, 64'h1);
        chk("rst_busy",  {63'h0, busy_o},  64'h0);
        for (int i = 0; i < 16; i++) begin
            srcA_i = 4'(i);
            srcB_i = 4'(15 - i);
            #1;
            chk("rst_valA", valA_o, (i == 15) ? 64'h0 : 64'(i));
            chk("rst_valB", valB_o, (i == 0) ? 64'h0 : 64'(15 - i));
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic rand_run(input int n, input bit allow_halt);
        logic [3:0] ic;
        for (int k = 0; k < n; k++) begin
            ic = 4'($urandom_range(0, 15));
            if (ic == 4'h1 && !(allow_halt && $urandom_range(0, 9) == 0)) ic = 4'h0;
            cycle($urandom_range(0, 3) != 0, ic, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(1, 4'h2, 4'h3);
        idle(1, 4'hF, 4'h3);
        // IRMOVL rB=3
        cycle(1'b1, 4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0, 4'h3, 4'h3);
        idle(3, 4'h3, 4'h5);
        // RRMOVL rB=5 with cnd=0, then cnd=1
        cycle(1'b1, 4'h2, 4'h1, 4'h5, 1'b0, 64'hAA, 64'h0, 4'h5, 4'h5);
        idle(2, 4'h5, 4'h3);
        cycle(1'b1, 4'h2, 4'h1, 4'h5, 1'b1, 64'hAA, 64'h0, 4'h5, 4'h5);
        idle(3, 4'h5, 4'h4);
        // POPL %rsp: E then M both target register 4
        cycle(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h55, 4'h4, 4'h4);
        idle(4, 4'h4, 4'h4);
        // ALU rB=7 with a reader on register 7 during the write cycle
        cycle(1'b1, 4'h6, 4'h0, 4'h7, 1'b0, 64'h99, 64'h0, 4'h7, 4'h7);
        idle(3, 4'h7, 4'h7);
        // Undefined icode behaves as NOP
        cycle(1'b1, 4'hD, 4'h2, 4'h2, 1'b1, 64'hDEAD, 64'hBEEF, 4'h2, 4'h2);
        idle(2, 4'h2, 4'h2);
        rand_run(400, 1'b0);
        idle(3, 4'h1, 4'h4);
        // HALT, then ignored IRMOVL rB=1
        cycle(1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, 4'h1, 4'h1);
        for (int k = 0; k < 4; k++) cycle(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h777, 64'h0, 4'h1, 4'h1);
        do_reset();
        for (int r = 0; r < 4; r++) begin
            rand_run(150, 1'b1);
            do_reset();
        end
        idle(2, 4'h0, 4'hE);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
